trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The module SHALL have the following ports, clock and reset first. The reset port rst_n SHALL be asynchronous and active-low.
  clk  input  1  sole clock; all state changes on its rising edge
  rst_n  input  1  asynchronous, active-low reset
  trap_req  input  1  pipeline reports an exception or interrupt this cycle
  trap_cause  input  32  mcause value; bit 31 = interrupt, bits 4:0 = code
  trap_pc  input  32  PC of the faulting or interrupted instruction
  trap_tval  input  32  mtval value (bad address or instruction)
  mret_req  input  1  pipeline is retiring an MRET this cycle
  mstatus_in  input  32  current mstatus from the CSR file
  mepc_in  input  32  current mepc from the CSR file
  mtvec_in  input  32  current mtvec from the CSR file
  csr_w  output  1  CSR write strobe to the CSR file
  csr_waddr  output  12  CSR write address
  csr_wdata  output  32  CSR write data
  csr_wsc_mode  output  2  write mode; always 2'b01 (plain write)
  redirect_valid  output  1  one-cycle pulse: fetch SHALL jump to redirect_pc
  redirect_pc  output  32  fetch target for the redirect
  busy  output  1  high while the sequence is in flight; the pipeline stalls on it

Function
REQ-002 The FSM SHALL have the states IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS and REDIR.
REQ-003 In IDLE with trap_req=1, the module SHALL capture trap_pc, trap_cause, trap_tval and mstatus_in and go to W_EPC.
REQ-004 In IDLE with mret_req=1 and trap_req=0, the module SHALL capture mepc_in and mstatus_in and go to M_STATUS.
REQ-005 If trap_req and mret_req are both high, the trap SHALL win and the MRET SHALL be dropped.
REQ-006 Each W_* and M_STATUS state SHALL last exactly one cycle, with csr_w=1 and csr_wsc_mode=2'b01, and SHALL drive the following address and data:
  W_EPC: address 0x341, data = captured pc with bits 1:0 cleared
  W_CAUSE: address 0x342, data = captured cause
  W_TVAL: address 0x343, data = captured tval
  W_STATUS (trap entry): address 0x300, data = captured mstatus with MPIE(7) = old MIE(3), MIE = 0, MPP(12:11) = 2'b11, all other bits unchanged
  M_STATUS (MRET): address 0x300, data = captured mstatus with MIE = old MPIE, MPIE = 1, MPP = 2'b11, all other bits unchanged
REQ-007 The state order SHALL be W_EPC -> W_CAUSE -> W_TVAL -> W_STATUS -> REDIR for a trap, and M_STATUS -> REDIR for an MRET.
REQ-008 REDIR SHALL last one cycle with redirect_valid=1 and csr_w=0, then return to IDLE.
REQ-009 The trap redirect_pc SHALL be computed from mtvec_in sampled in REDIR, with base = {mtvec[31:2], 2'b00}:
  if mtvec[1:0]=01 and cause[31]=1: base + (cause[4:0] << 2), 32-bit arithmetic that wraps modulo 2^32
  otherwise: base
REQ-010 The MRET redirect_pc SHALL be the captured mepc with bits 1:0 cleared.
REQ-011 Latencies SHALL be fixed:
  trap: accepted at edge N, redirect_valid high in cycle N+5
  MRET: accepted at edge N, redirect_valid high in cycle N+2
REQ-012 busy SHALL be high in every non-IDLE state, including REDIR; trap_req and mret_req SHALL be ignored whenever busy is high.
REQ-013 Outside the W_*, M_STATUS and REDIR states, csr_w, redirect_valid, csr_waddr, csr_wdata and redirect_pc SHALL all be 0; csr_wsc_mode SHALL be 2'b01 at all times.

Reset
REQ-014 While rst_n=0, the FSM SHALL be in IDLE, all captured registers SHALL be 0 and all outputs SHALL be 0, except csr_wsc_mode, which SHALL be 2'b01.
REQ-015 Assertion of rst_n mid-sequence SHALL abort the sequence immediately; no further CSR write or redirect SHALL be issued.

Structure
REQ-016 A shared package SHALL hold the state enum, the CSR address constants (0x300, 0x305, 0x341, 0x342, 0x343) and the mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
REQ-017 The block SHALL be a single module with no sub-module; the mstatus transforms and the vector computation SHALL be combinational logic inside it.

Verification
REQ-018 The bench SHALL cover at least the following directed scenarios:
  Trap: trap_req, pc=0x0000_1004, cause=2, tval=0xDEAD_BEEF, mstatus=0x88, mtvec=0x100 -> writes 0x341=0x1004, 0x342=2, 0x343=0xDEADBEEF, 0x300=0x1880 on consecutive cycles; redirect_pc=0x100 at N+5.
  Vectored interrupt: cause=0x8000_0007, mtvec=0x201 -> redirect_pc=0x21C.
  MRET: mret_req, mepc=0x2002, mstatus=0x1880 -> write 0x300=0x1888; redirect_pc=0x2000 at N+2.
  Collision and busy: trap_req and mret_req together -> trap sequence only; a second trap_req during busy -> no extra writes.
  Reset mid-sequence: rst_n low during W_CAUSE -> csr_w=0 and redirect_valid=0 immediately; IDLE after release.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Holds the sequencer state enum, the machine CSR addresses it writes or
// reads, the mstatus bit positions touched on trap entry and MRET, and the
// fixed CSR write mode.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_TVAL   = 3'd3,
    W_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIR    = 3'd6
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [1:0] CSR_WSC_WRITE = 2'b01;

endpackage

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer.
// On a trap it writes mepc, mcause, mtval and mstatus on four consecutive
// cycles and then redirects fetch to the trap vector; on an MRET it writes
// mstatus once and redirects fetch to mepc.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   trap_req/cause/pc/tval  trap report from the pipeline
//   mret_req              MRET retiring this cycle
//   mstatus_in, mepc_in, mtvec_in  current CSR values
//   csr_w, csr_waddr, csr_wdata, csr_wsc_mode  CSR write port
//   redirect_valid, redirect_pc  one-cycle fetch redirect
//   busy                  high whenever a sequence is in flight
//
// Handshake: trap_req / mret_req are single-cycle requests sampled only when
// busy is low; a request seen while busy is high is dropped, never queued.
// csr_w and redirect_valid are one-cycle strobes with no back-pressure.
module trap_sequencer
  import trap_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mepc_in,
  input  logic [31:0] mtvec_in,
  output logic        csr_w,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  csr_wsc_mode,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_t      state;
  // cap_pc holds the trapping pc on trap entry and mepc on MRET.
  logic [31:0] cap_pc;
  logic [31:0] cap_cause;
  logic [31:0] cap_tval;
  logic [31:0] cap_status;
  logic        cap_mret;

  logic [31:0] entry_status;
  logic [31:0] mret_status;
  logic [31:0] vec_base;
  logic [31:0] trap_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_pc     <= '0;
      cap_cause  <= '0;
      cap_tval   <= '0;
      cap_status <= '0;
      cap_mret   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A trap outranks a simultaneous MRET; the MRET is dropped.
          if (trap_req) begin
            cap_pc     <= trap_pc;
            cap_cause  <= trap_cause;
            cap_tval   <= trap_tval;
            cap_status <= mstatus_in;
            cap_mret   <= 1'b0;
            state      <= W_EPC;
          end else if (mret_req) begin
            cap_pc     <= mepc_in;
            cap_status <= mstatus_in;
            cap_mret   <= 1'b1;
            state      <= M_STATUS;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_TVAL;
        W_TVAL:   state <= W_STATUS;
        W_STATUS: state <= REDIR;
        M_STATUS: state <= REDIR;
        REDIR:    state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  always_comb begin
    entry_status                                = cap_status;
    entry_status[MSTATUS_MPIE]                  = cap_status[MSTATUS_MIE];
    entry_status[MSTATUS_MIE]                   = 1'b0;
    entry_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // MRET: MIE <- MPIE, MPIE <- 1, MPP stays M (only M-mode is implemented).
  always_comb begin
    mret_status                                = cap_status;
    mret_status[MSTATUS_MIE]                   = cap_status[MSTATUS_MPIE];
    mret_status[MSTATUS_MPIE]                  = 1'b1;
    mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // mtvec is read live in REDIR so a CSR write landing during the sequence
  // is honoured. Only interrupts are vectored; the add wraps at 32 bits.
  assign vec_base = {mtvec_in[31:2], 2'b00};
  always_comb begin
    trap_target = vec_base;
    if (mtvec_in[1:0] == 2'b01 && cap_cause[31])
      trap_target = vec_base + {25'd0, cap_cause[4:0], 2'b00};
  end

  always_comb begin
    csr_w          = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state)
      W_EPC: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {cap_pc[31:2], 2'b00};
      end
      W_CAUSE: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cap_cause;
      end
      W_TVAL: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = cap_tval;
      end
      W_STATUS: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = entry_status;
      end
      M_STATUS: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mret_status;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = cap_mret ? {cap_pc[31:2], 2'b00} : trap_target;
      end
      default: ;
    endcase
  end

  assign csr_wsc_mode = CSR_WSC_WRITE;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus randomized requests,
// checked by a scoreboard of expected CSR writes and redirects, each tagged
// with the cycle in which it has to appear.
module tb_trap_sequencer;

  localparam int W = 61; // {cycle[15:0], is_redirect, addr[11:0], data[31:0]}

  logic        clk;
  logic        rst_n;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic [31:0] mstatus_in;
  logic [31:0] mepc_in;
  logic [31:0] mtvec_in;
  logic        csr_w;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_wsc_mode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  trap_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .mstatus_in     (mstatus_in),
    .mepc_in        (mepc_in),
    .mtvec_in       (mtvec_in),
    .csr_w          (csr_w),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_wsc_mode   (csr_wsc_mode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int busy_start = -1;
  int busy_end   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int cy, input bit is_redir, input logic [11:0] addr,
                         input logic [31:0] data);
    logic [15:0] c16;
    c16 = cy[15:0];
    exp_q.push_back({c16, is_redir, addr, data});
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_entry_status(input logic [31:0] ms);
    logic [31:0] mie;
    mie = (ms >> 3) & 32'd1;
    return (ms & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] model_mret_status(input logic [31:0] ms);
    logic [31:0] mpie;
    mpie = (ms >> 7) & 32'd1;
    return (ms & ~32'h0000_1888) | (mpie << 3) | 32'h0000_1880;
  endfunction

  function automatic logic [31:0] model_vector(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec - (tvec % 4);
    if ((tvec % 4) == 1 && cause >= 32'h8000_0000)
      return base + (cause % 32) * 4;
    return base;
  endfunction

  // ---------------- driver ----------------
  // Presents a request for one cycle; the model decides whether the DUT is
  // idle in that cycle and, if so, queues the whole expected response.
  task automatic issue(input bit t, input bit m, input logic [31:0] pc,
                       input logic [31:0] cause, input logic [31:0] tval,
                       input logic [31:0] ms, input logic [31:0] mepc,
                       input logic [31:0] tvec);
    int  c;
    int  a;
    bit  idle;
    @(posedge clk); #1;
    c    = cyc;
    idle = (c > busy_end);
    if (idle) mtvec_in = tvec;
    trap_req   = t;
    mret_req   = m;
    trap_pc    = pc;
    trap_cause = cause;
    trap_tval  = tval;
    mstatus_in = ms;
    mepc_in    = mepc;
    a = c + 1;
    if (idle && t) begin
      push_ev(a,     1'b0, 12'h341, pc & ~32'd3);
      push_ev(a + 1, 1'b0, 12'h342, cause);
      push_ev(a + 2, 1'b0, 12'h343, tval);
      push_ev(a + 3, 1'b0, 12'h300, model_entry_status(ms));
      push_ev(a + 4, 1'b1, 12'h000, model_vector(tvec, cause));
      busy_start = a;
      busy_end   = a + 4;
    end else if (idle && m) begin
      push_ev(a,     1'b0, 12'h300, model_mret_status(ms));
      push_ev(a + 1, 1'b1, 12'h000, mepc & ~32'd3);
      busy_start = a;
      busy_end   = a + 1;
    end
    @(posedge clk); #1;
    trap_req = 1'b0;
    mret_req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    bit           exp_busy;
    exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
    chk("busy", {63'd0, busy}, {63'd0, exp_busy});
    chk("csr_wsc_mode", {62'd0, csr_wsc_mode}, 64'd1);
    while (exp_q.size() > 0 && int'(exp_q[0][60:45]) < cyc) begin
      e = exp_q.pop_front();
      chk("missing_event_cycle", 64'(cyc), 64'(e[60:45]));
    end
    if (csr_w || redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {62'd0, csr_w, redirect_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(e[60:45]));
        if (e[44]) begin
          chk("redirect_valid", {63'd0, redirect_valid}, 64'd1);
          chk("redir_csr_w", {63'd0, csr_w}, 64'd0);
          chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, e[31:0]});
        end else begin
          chk("csr_w", {63'd0, csr_w}, 64'd1);
          chk("write_redirect_valid", {63'd0, redirect_valid}, 64'd0);
          chk("csr_waddr", {52'd0, csr_waddr}, {52'd0, e[43:32]});
          chk("csr_wdata", {32'd0, csr_wdata}, {32'd0, e[31:0]});
        end
      end
    end else begin
      chk("idle_outputs_zero", {20'd0, csr_waddr, csr_wdata}, 64'd0);
      chk("idle_redirect_pc_zero", {32'd0, redirect_pc}, 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic [31:0] cause;
    logic [31:0] tvec;
    int          kind;
    rst_n      = 1'b0;
    trap_req   = 1'b0;
    mret_req   = 1'b0;
    trap_cause = '0;
    trap_pc    = '0;
    trap_tval  = '0;
    mstatus_in = '0;
    mepc_in    = '0;
    mtvec_in   = '0;
    #1;
    chk("reset_csr_w", {63'd0, csr_w}, 64'd0);
    chk("reset_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_wdata", {32'd0, csr_wdata}, 64'd0);
    chk("reset_mode", {62'd0, csr_wsc_mode}, 64'd1);
    wait_cycles(3);
    @(negedge clk); rst_n = 1'b1;
    wait_cycles(2);

    // Basic synchronous exception.
    issue(1, 0, 32'h0000_1004, 32'd2, 32'hDEAD_BEEF, 32'h88, 32'h0, 32'h100);
    wait_cycles(6);
    // Vectored interrupt.
    issue(1, 0, 32'h0000_4000, 32'h8000_0007, 32'h0, 32'h0, 32'h0, 32'h201);
    wait_cycles(6);
    // Vector add wraps past 2^32.
    issue(1, 0, 32'h0000_0010, 32'h8000_001F, 32'h1, 32'h8, 32'h0, 32'hFFFF_FFF1);
    wait_cycles(6);
    // Exception with vectored mtvec stays on the base.
    issue(1, 0, 32'h0000_0020, 32'h0000_001F, 32'h2, 32'h0, 32'h0, 32'h0000_0401);
    wait_cycles(6);
    // MRET.
    issue(0, 1, 32'h0, 32'h0, 32'h0, 32'h1880, 32'h2002, 32'h100);
    wait_cycles(3);
    // Collision, then a trap while busy that must be ignored.
    issue(1, 1, 32'h0000_3000, 32'd5, 32'h55, 32'h8, 32'h7000, 32'h300);
    issue(1, 0, 32'h0000_9000, 32'd6, 32'h66, 32'h0, 32'h0, 32'h300);
    wait_cycles(6);

    // Reset during W_CAUSE aborts the sequence.
    issue(1, 0, 32'h0000_5000, 32'd4, 32'h44, 32'h88, 32'h0, 32'h500);
    @(posedge clk); #2;
    chk("pre_abort_csr_w", {63'd0, csr_w}, 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    busy_start = -1;
    busy_end   = -1;
    chk("abort_csr_w", {63'd0, csr_w}, 64'd0);
    chk("abort_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    wait_cycles(2);
    @(negedge clk); rst_n = 1'b1;
    wait_cycles(2);
    chk("post_reset_idle", {63'd0, busy}, 64'd0);
    issue(1, 0, 32'h0000_6006, 32'd11, 32'h77, 32'h0, 32'h0, 32'h600);
    wait_cycles(6);

    // Randomized traffic, including requests that land while busy.
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      r    = $urandom;
      tvec = {r[31:2], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) cause = 32'h8000_0000 | $urandom_range(0, 31);
      else cause = $urandom;
      case (kind)
        0: issue(1, 0, $urandom, cause, $urandom, $urandom, $urandom, tvec);
        1: issue(0, 1, $urandom, cause, $urandom, $urandom, $urandom, tvec);
        2: issue(1, 1, $urandom, cause, $urandom, $urandom, $urandom, tvec);
        default: wait_cycles(1);
      endcase
      wait_cycles($urandom_range(0, 5));
    end

    for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
